// File: rtl/l2_cache_param_if.sv
// l2_cache_param_if
// Purpose: bundles the request side (mem_*), the flush handshake and the
// backing-memory side (pmem_*) of the set-associative L2 cache.
// Modports:
//   slave  - the cache: takes mem requests, answers them, issues pmem requests.
//   master - the environment: issues mem requests and flushes, answers pmem requests.
// Signals:
//   mem_read/mem_write/mem_address/mem_wdata -> request, held until mem_resp
//   mem_resp/mem_rdata                       <- one-cycle completion, read line
//   flush_req -> level flush request, flush_done <- one-cycle completion
//   pmem_read/pmem_write/pmem_address/pmem_wdata <- memory request, held until pmem_resp
//   pmem_resp/pmem_rdata                         -> memory completion, fill line
interface l2_cache_param_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_resp;
   logic [LINE_W-1:0] mem_rdata;
   logic              flush_req;
   logic              flush_done;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, flush_req, pmem_resp, pmem_rdata,
      output mem_resp, mem_rdata, flush_done, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, flush_req, pmem_resp, pmem_rdata,
      input  mem_resp, mem_rdata, flush_done, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/l2_cache_param.sv
// l2_cache_param
// Purpose: WAYS-way set-associative write-back, write-allocate (no fill on
// write miss) cache with tree-PLRU replacement and a full-cache flush.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous assert, active-low reset
//   bus   - l2_cache_param_if.slave carrying the mem, flush and pmem signals
module l2_cache_param #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int WAYS   = 4,
   parameter int SETS   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   l2_cache_param_if.slave       bus
);
   localparam int OFF = $clog2(LINE_W / 8);
   localparam int IDX = $clog2(SETS);
   localparam int WB  = $clog2(WAYS);
   localparam int TAG = ADDR_W - IDX - OFF;
   localparam int NB  = WAYS - 1;

   typedef enum logic [2:0] {
      IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WB-1:0]     victim_q, victim_d;
   logic [IDX+WB-1:0] cnt_q, cnt_d;           // flush cursor, {set, way}

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [NB-1:0]     plru_q  [SETS];
   logic [TAG-1:0]    tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];

   logic [IDX-1:0]    req_idx;
   logic [TAG-1:0]    req_tag;
   logic [IDX-1:0]    f_set;
   logic [WB-1:0]     f_way;
   logic              unused_off;

   assign req_idx    = bus.mem_address[OFF +: IDX];
   assign req_tag    = bus.mem_address[ADDR_W-1 -: TAG];
   assign f_set      = cnt_q[WB +: IDX];
   assign f_way      = cnt_q[WB-1:0];
   assign unused_off = ^bus.mem_address[OFF-1:0];

   // Tree PLRU: level l of the tree decides way bit l, so the root splits
   // even/odd ways. A node bit points toward the less recently used side.
   function automatic logic [WB-1:0] plru_victim(input logic [NB-1:0] bits);
      logic [WB-1:0] way;
      logic          b;
      int            node;
      int            path;
      way  = '0;
      path = 0;
      for (int l = 0; l < WB; l++) begin
         node = (1 << l) - 1 + path;
         b    = 1'b0;
         for (int n = 0; n < NB; n++) if (n == node) b = bits[n];
         way[l] = b;
         path   = path * 2 + int'(b);
      end
      return way;
   endfunction

   function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits,
                                                input logic [WB-1:0] way);
      logic [NB-1:0] nb;
      int            node;
      int            path;
      nb   = bits;
      path = 0;
      for (int l = 0; l < WB; l++) begin
         node = (1 << l) - 1 + path;
         for (int n = 0; n < NB; n++) if (n == node) nb[n] = ~way[l];
         path = path * 2 + int'(way[l]);
      end
      return nb;
   endfunction

   logic          hit;
   logic [WB-1:0] hit_way;
   logic [WB-1:0] victim;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = w[WB-1:0];
         end
      end
      // Descending scan so the lowest-index invalid way wins.
      victim = plru_victim(plru_q[req_idx]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) victim = w[WB-1:0];
      end
   end

   logic              mem_resp_c, flush_done_c, pmem_read_c, pmem_write_c;
   logic [ADDR_W-1:0] pmem_address_c;
   logic [LINE_W-1:0] pmem_wdata_c, mem_rdata_c;
   logic              line_we, line_dirty, clr_en, touch_en;
   logic [WB-1:0]     line_way, clr_way, touch_way;
   logic [IDX-1:0]    clr_set;
   logic [LINE_W-1:0] line_data;

   always_comb begin
      state_d        = state_q;
      victim_d       = victim_q;
      cnt_d          = cnt_q;
      mem_resp_c     = 1'b0;
      mem_rdata_c    = '0;
      flush_done_c   = 1'b0;
      pmem_read_c    = 1'b0;
      pmem_write_c   = 1'b0;
      pmem_address_c = '0;
      pmem_wdata_c   = '0;
      line_we        = 1'b0;
      line_way       = hit_way;
      line_data      = bus.mem_wdata;
      line_dirty     = 1'b1;
      clr_en         = 1'b0;
      clr_set        = req_idx;
      clr_way        = victim_q;
      touch_en       = 1'b0;
      touch_way      = hit_way;
      case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) state_d = COMPARE;
            else if (bus.flush_req)            state_d = FLUSH_SCAN;
         end
         COMPARE: begin
            if (hit) begin
               mem_resp_c = 1'b1;
               touch_en   = 1'b1;
               if (bus.mem_read) mem_rdata_c = data_q[req_idx][hit_way];
               else              line_we     = 1'b1;
               state_d = IDLE;
            end else begin
               victim_d = victim;
               if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                  state_d = WRITEBACK;
               end else if (bus.mem_read) begin
                  state_d = ALLOCATE;
               end else begin
                  // Write miss: install the write line without a fill.
                  line_we   = 1'b1;
                  line_way  = victim;
                  touch_en  = 1'b1;
                  touch_way = victim;
                  state_d   = COMPARE;
               end
            end
         end
         WRITEBACK: begin
            pmem_write_c   = 1'b1;
            pmem_address_c = {tag_q[req_idx][victim_q], req_idx, {OFF{1'b0}}};
            pmem_wdata_c   = data_q[req_idx][victim_q];
            if (bus.pmem_resp) begin
               clr_en = 1'b1;
               if (bus.mem_read) begin
                  state_d = ALLOCATE;
               end else begin
                  line_we   = 1'b1;
                  line_way  = victim_q;
                  touch_en  = 1'b1;
                  touch_way = victim_q;
                  state_d   = COMPARE;
               end
            end
         end
         ALLOCATE: begin
            pmem_read_c    = 1'b1;
            pmem_address_c = {req_tag, req_idx, {OFF{1'b0}}};
            if (bus.pmem_resp) begin
               line_we    = 1'b1;
               line_way   = victim_q;
               line_data  = bus.pmem_rdata;
               line_dirty = 1'b0;
               touch_en   = 1'b1;
               touch_way  = victim_q;
               state_d    = COMPARE;
            end
         end
         FLUSH_SCAN: begin
            if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
               state_d = FLUSH_WB;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) state_d = FLUSH_DONE;
            end
         end
         FLUSH_WB: begin
            pmem_write_c   = 1'b1;
            pmem_address_c = {tag_q[f_set][f_way], f_set, {OFF{1'b0}}};
            pmem_wdata_c   = data_q[f_set][f_way];
            if (bus.pmem_resp) begin
               clr_en  = 1'b1;
               clr_set = f_set;
               clr_way = f_way;
               cnt_d   = cnt_q + 1'b1;
               state_d = (&cnt_q) ? FLUSH_DONE : FLUSH_SCAN;
            end
         end
         FLUSH_DONE: begin
            flush_done_c = 1'b1;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         victim_q <= '0;
         cnt_q    <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         cnt_q    <= cnt_d;
         // A writeback completing on a write miss clears then re-sets dirty;
         // the install below is ordered last so it wins.
         if (clr_en) dirty_q[clr_set][clr_way] <= 1'b0;
         if (line_we) begin
            valid_q[req_idx][line_way] <= 1'b1;
            dirty_q[req_idx][line_way] <= line_dirty;
         end
         if (touch_en) plru_q[req_idx] <= plru_touch(plru_q[req_idx], touch_way);
      end
   end

   // Tag and data storage need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[req_idx][line_way]  <= req_tag;
         data_q[req_idx][line_way] <= line_data;
      end
   end

   assign bus.mem_resp     = mem_resp_c;
   assign bus.mem_rdata    = mem_rdata_c;
   assign bus.flush_done   = flush_done_c;
   assign bus.pmem_read    = pmem_read_c;
   assign bus.pmem_write   = pmem_write_c;
   assign bus.pmem_address = pmem_address_c;
   assign bus.pmem_wdata   = pmem_wdata_c;
endmodule

// File: tb/tb_l2_cache_param.sv
// tb_l2_cache_param
// Purpose: directed self-checking bench for l2_cache_param (default
// parameters). A behavioural backing memory answers pmem requests five
// cycles after it first sees them and logs every transfer.
module tb_l2_cache_param;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   l2_cache_param_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   l2_cache_param #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WAYS(4), .SETS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int flush_done_cnt = 0;

   task automatic chk(input string tag, input logic ok,
                      input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   logic              log_wr   [$];
   logic [ADDR_W-1:0] log_addr [$];
   logic [LINE_W-1:0] log_data [$];

   function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
      return {4{a, ~a}};
   endfunction

   task automatic clear_log();
      log_wr.delete();
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin : pmem_model
      logic [ADDR_W-1:0] a;
      logic              aborted;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
            chk("pmem_exclusive", (bus.pmem_read & bus.pmem_write) === 1'b0,
                bus.pmem_read & bus.pmem_write, 1'b0);
            a = bus.pmem_address;
            log_wr.push_back(bus.pmem_write);
            log_addr.push_back(a);
            log_data.push_back(bus.pmem_write ? bus.pmem_wdata : '0);
            aborted = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               else if (!aborted)
                  chk("pmem_addr_stable", bus.pmem_address === a, bus.pmem_address, a);
            end
            if (!aborted) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = bus.pmem_read ? mem_line(a) : '0;
               @(negedge clk);
               bus.pmem_resp  = 1'b0;
               bus.pmem_rdata = '0;
            end
         end
      end
   end

   initial begin : flush_monitor
      forever begin
         @(negedge clk);
         if (bus.flush_done) flush_done_cnt++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wdata,
                         output logic [LINE_W-1:0] rdata, output int lat);
      @(negedge clk);
      bus.mem_read    = !wr;
      bus.mem_write   = wr;
      bus.mem_address = addr;
      bus.mem_wdata   = wdata;
      lat = 1;
      for (int i = 0; i < 300 && !bus.mem_resp; i++) begin
         @(negedge clk);
         lat++;
      end
      chk("mem_resp_arrives", bus.mem_resp === 1'b1, bus.mem_resp, 1'b1);
      rdata = bus.mem_rdata;
      $display("[TB] %s addr=%h lat=%0d rdata=%h", wr ? "WR" : "RD", addr, lat, rdata);
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      chk("mem_resp_one_cycle", bus.mem_resp === 1'b0, bus.mem_resp, 1'b0);
   endtask

   task automatic run_flush(input string tag);
      @(negedge clk);
      bus.flush_req = 1'b1;
      for (int i = 0; i < 500 && !bus.flush_done; i++) @(negedge clk);
      chk(tag, bus.flush_done === 1'b1, bus.flush_done, 1'b1);
      bus.flush_req = 1'b0;
      $display("[TB] flush %s complete, pmem transfers=%0d", tag, log_wr.size());
   endtask

   initial begin : stimulus
      logic [LINE_W-1:0] rd;
      logic [LINE_W-1:0] w_a, w_b, w_c;
      logic [ADDR_W-1:0] s3 [5];
      logic [ADDR_W-1:0] s4 [5];
      int                lat;
      int                fd0;

      w_a = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      w_b = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      w_c = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
      s3  = '{16'h00B0, 16'h0130, 16'h01B0, 16'h0230, 16'h02B0};
      s4  = '{16'h00C0, 16'h0140, 16'h01C0, 16'h0240, 16'h02C0};

      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = '0;
      bus.mem_wdata   = '0;
      bus.flush_req   = 1'b0;

      #2 rst_n = 1'b0;
      bus.mem_read    = 1'b1;
      bus.flush_req   = 1'b1;
      bus.mem_address = 16'h1230;
      repeat (2) @(negedge clk);
      chk("rst_mem_resp",     bus.mem_resp === 1'b0,           bus.mem_resp,     1'b0);
      chk("rst_flush_done",   bus.flush_done === 1'b0,         bus.flush_done,   1'b0);
      chk("rst_pmem_read",    bus.pmem_read === 1'b0,          bus.pmem_read,    1'b0);
      chk("rst_pmem_write",   bus.pmem_write === 1'b0,         bus.pmem_write,   1'b0);
      chk("rst_pmem_address", bus.pmem_address === 16'h0000,   bus.pmem_address, 16'h0000);
      chk("rst_pmem_wdata",   bus.pmem_wdata === 128'h0,       bus.pmem_wdata,   128'h0);
      chk("rst_mem_rdata",    bus.mem_rdata === 128'h0,        bus.mem_rdata,    128'h0);
      $display("[TB] reset outputs checked");
      bus.mem_read  = 1'b0;
      bus.flush_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      clear_log();
      do_req(1'b0, 16'h1230, '0, rd, lat);
      chk("cold_rdata", rd === mem_line(16'h1230), rd, mem_line(16'h1230));
      chk("cold_pmem_count", log_wr.size() == 1, log_wr.size(), 1);
      if (log_wr.size() > 0) begin
         chk("cold_pmem_is_read", log_wr[0] === 1'b0, log_wr[0], 1'b0);
         chk("cold_pmem_addr", log_addr[0] === 16'h1230, log_addr[0], 16'h1230);
      end
      do_req(1'b0, 16'h1230, '0, rd, lat);
      chk("warm_latency", lat == 2, lat, 2);
      chk("warm_rdata", rd === mem_line(16'h1230), rd, mem_line(16'h1230));
      do_req(1'b0, 16'h123C, '0, rd, lat);
      chk("offset_latency", lat == 2, lat, 2);
      chk("offset_rdata", rd === mem_line(16'h1230), rd, mem_line(16'h1230));
      chk("warm_no_pmem", log_wr.size() == 1, log_wr.size(), 1);

      do_reset();
      clear_log();
      for (int i = 0; i < 4; i++) do_req(1'b0, s3[i], '0, rd, lat);
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, s3[i], '0, rd, lat);
         chk("set3_hit_latency", lat == 2, lat, 2);
      end
      do_req(1'b0, s3[4], '0, rd, lat);
      chk("set3_new_rdata", rd === mem_line(s3[4]), rd, mem_line(s3[4]));
      chk("set3_pmem_count", log_wr.size() == 5, log_wr.size(), 5);
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, s3[i], '0, rd, lat);
         chk("set3_survivor_hit", lat == 2, lat, 2);
      end
      do_req(1'b0, s3[3], '0, rd, lat);
      chk("set3_way3_evicted", lat > 2, lat, 3);
      chk("set3_refill_count", log_wr.size() == 6, log_wr.size(), 6);

      do_reset();
      clear_log();
      do_req(1'b1, 16'h0040, w_a, rd, lat);
      chk("wmiss_latency", lat == 3, lat, 3);
      chk("wmiss_no_fill", log_wr.size() == 0, log_wr.size(), 0);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, s4[i], '0, rd, lat);
         chk("set4_rdata", rd === mem_line(s4[i]), rd, mem_line(s4[i]));
      end
      chk("set4_pmem_count", log_wr.size() == 6, log_wr.size(), 6);
      if (log_wr.size() >= 5) begin
         chk("wb_is_write", log_wr[3] === 1'b1, log_wr[3], 1'b1);
         chk("wb_addr", log_addr[3] === 16'h0040, log_addr[3], 16'h0040);
         chk("wb_data", log_data[3] === w_a, log_data[3], w_a);
         chk("wb_then_read", log_wr[4] === 1'b0, log_wr[4], 1'b0);
         chk("wb_then_read_addr", log_addr[4] === 16'h0240, log_addr[4], 16'h0240);
      end

      do_reset();
      do_req(1'b0, 16'h0000, '0, rd, lat);
      do_req(1'b1, 16'h0080, w_a, rd, lat);
      do_req(1'b0, 16'h0070, '0, rd, lat);
      do_req(1'b0, 16'h00F0, '0, rd, lat);
      do_req(1'b1, 16'h0170, w_b, rd, lat);
      clear_log();
      fd0 = flush_done_cnt;
      run_flush("flush1_done");
      repeat (5) @(negedge clk);
      chk("flush1_single_done", (flush_done_cnt - fd0) == 1, flush_done_cnt - fd0, 1);
      chk("flush1_pmem_count", log_wr.size() == 2, log_wr.size(), 2);
      if (log_wr.size() >= 2) begin
         chk("flush1_both_writes", (log_wr[0] & log_wr[1]) === 1'b1, log_wr[0] & log_wr[1], 1'b1);
         chk("flush1_addr0", log_addr[0] === 16'h0080, log_addr[0], 16'h0080);
         chk("flush1_data0", log_data[0] === w_a, log_data[0], w_a);
         chk("flush1_addr1", log_addr[1] === 16'h0170, log_addr[1], 16'h0170);
         chk("flush1_data1", log_data[1] === w_b, log_data[1], w_b);
      end
      do_req(1'b0, 16'h0080, '0, rd, lat);
      chk("post_flush_hit0", lat == 2, lat, 2);
      chk("post_flush_data0", rd === w_a, rd, w_a);
      do_req(1'b0, 16'h0170, '0, rd, lat);
      chk("post_flush_hit1", lat == 2, lat, 2);
      chk("post_flush_data1", rd === w_b, rd, w_b);
      clear_log();
      run_flush("flush2_done");
      repeat (3) @(negedge clk);
      chk("flush2_nothing_dirty", log_wr.size() == 0, log_wr.size(), 0);

      do_reset();
      clear_log();
      @(negedge clk);
      bus.mem_read    = 1'b1;
      bus.mem_address = 16'h0500;
      for (int i = 0; i < 50 && !bus.pmem_read; i++) @(negedge clk);
      chk("alloc_entered", bus.pmem_read === 1'b1, bus.pmem_read, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pmem_read_low", bus.pmem_read === 1'b0, bus.pmem_read, 1'b0);
      chk("async_pmem_addr_zero", bus.pmem_address === 16'h0000, bus.pmem_address, 16'h0000);
      $display("[TB] reset asserted mid-allocate");
      bus.mem_read = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      clear_log();
      do_req(1'b0, 16'h0500, '0, rd, lat);
      chk("after_reset_miss", lat > 2, lat, 3);
      chk("after_reset_rdata", rd === mem_line(16'h0500), rd, mem_line(16'h0500));
      chk("after_reset_pmem_count", log_wr.size() == 1, log_wr.size(), 1);

      do_reset();
      do_req(1'b1, 16'h0010, w_c, rd, lat);
      clear_log();
      fd0 = flush_done_cnt;
      @(negedge clk);
      bus.mem_read    = 1'b1;
      bus.mem_address = 16'h1230;
      bus.flush_req   = 1'b1;
      for (int i = 0; i < 300 && !bus.mem_resp; i++) @(negedge clk);
      chk("race_resp", bus.mem_resp === 1'b1, bus.mem_resp, 1'b1);
      chk("race_rdata", bus.mem_rdata === mem_line(16'h1230), bus.mem_rdata, mem_line(16'h1230));
      chk("race_no_flush_yet", (flush_done_cnt - fd0) == 0, flush_done_cnt - fd0, 0);
      chk("race_only_fill", log_wr.size() == 1, log_wr.size(), 1);
      $display("[TB] RD addr=1230 completed with flush pending");
      @(posedge clk);
      #1;
      bus.mem_read = 1'b0;
      for (int i = 0; i < 500 && !bus.flush_done; i++) @(negedge clk);
      chk("race_flush_done", bus.flush_done === 1'b1, bus.flush_done, 1'b1);
      bus.flush_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("race_single_done", (flush_done_cnt - fd0) == 1, flush_done_cnt - fd0, 1);
      chk("race_pmem_count", log_wr.size() == 2, log_wr.size(), 2);
      if (log_wr.size() >= 2) begin
         chk("race_wb_is_write", log_wr[1] === 1'b1, log_wr[1], 1'b1);
         chk("race_wb_addr", log_addr[1] === 16'h0010, log_addr[1], 16'h0010);
         chk("race_wb_data", log_data[1] === w_c, log_data[1], w_c);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/l2_cache_param.md
L2_CACHE_PARAM -- requirements
Module: l2_cache_param

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of the mem and pmem buses.
REQ-002 Parameter LINE_W, default 128, cacheline width in bits; a power of two, at least 16.
REQ-003 Parameter WAYS, default 4, associativity; legal values are 2, 4 and 8.
REQ-004 Parameter SETS, default 8, number of sets; a power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 mem_read  in  1  line read request; held stable until mem_resp.
REQ-008 mem_write  in  1  full-line write request; held stable until mem_resp.
REQ-009 mem_address  in  ADDR_W  request byte address.
REQ-010 mem_wdata  in  LINE_W  write line.
REQ-011 mem_resp  out  1  one-cycle completion pulse.
REQ-012 mem_rdata  out  LINE_W  read line; valid while mem_resp=1.
REQ-013 flush_req  in  1  level request to write back all dirty lines.
REQ-014 flush_done  out  1  one-cycle pulse when the flush completes.
REQ-015 pmem_read, pmem_write  out  1 each  memory requests; held until pmem_resp.
REQ-016 pmem_address  out  ADDR_W  line-aligned memory address.
REQ-017 pmem_wdata  out  LINE_W  writeback line.
REQ-018 pmem_resp  in  1  memory completion pulse.
REQ-019 pmem_rdata  in  LINE_W  fill line; valid while pmem_resp=1.

Function
REQ-020 Address split: OFF=log2(LINE_W/8), IDX=log2(SETS), TAG=ADDR_W-IDX-OFF. Offset bits are ignored.
REQ-021 Per way and set, the cache holds valid, dirty, tag and data. Per set, it holds WAYS-1 tree-PLRU bits.
REQ-022 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
REQ-023 IDLE: when mem_read or mem_write is 1, go to COMPARE. Else, when flush_req is 1, go to FLUSH_SCAN. If both are present, the mem request wins.
REQ-024 COMPARE, hit: assert mem_resp that cycle and go to IDLE. Read-hit latency is 2 cycles from the request being seen in IDLE.
REQ-025 Read hit drives mem_rdata from the hit way.
REQ-026 Write hit stores mem_wdata in the hit way and sets its dirty bit.
REQ-027 Every hit and every install updates PLRU so the touched way is most-recently-used.
REQ-028 Victim selection: the lowest-index invalid way; if all ways are valid, the PLRU-indicated way.
REQ-029 COMPARE miss with a valid, dirty victim: go to WRITEBACK.
REQ-030 WRITEBACK drives pmem_write=1, pmem_address={victim tag, index, 0} and pmem_wdata=victim data until pmem_resp. It then clears the victim's dirty bit.
REQ-031 After a clean victim or a completed WRITEBACK: a read goes to ALLOCATE; a write installs mem_wdata directly (valid=1, dirty=1, tag updated) and returns to COMPARE. A write miss performs no fill.
REQ-032 ALLOCATE drives pmem_read=1 and pmem_address={request tag, index, 0} until pmem_resp. It then installs pmem_rdata (valid=1, dirty=0) and returns to COMPARE, which then hits.
REQ-033 pmem_read and pmem_write are never both 1. pmem_address and pmem_wdata are stable while either is 1.
REQ-034 FLUSH_SCAN walks a (set, way) counter from (0,0) to (SETS-1, WAYS-1), one entry per cycle. A valid, dirty entry goes to FLUSH_WB, which writes it back as in REQ-030, clears its dirty bit and resumes the scan at the next entry.
REQ-035 After the last entry, go to FLUSH_DONE. FLUSH_DONE pulses flush_done for one cycle and returns to IDLE.
REQ-036 Flush preserves valid bits and PLRU state. A mem request arriving during a flush waits until IDLE.
REQ-037 mem_resp and flush_done are 0 in every state other than those specified.

Reset
REQ-038 rst_n=0 immediately forces IDLE and clears all valid, dirty and PLRU bits and the flush counter.
REQ-039 While rst_n=0: mem_resp, flush_done, pmem_read and pmem_write are 0; pmem_address, pmem_wdata and mem_rdata are 0.
REQ-040 Reset during WRITEBACK, ALLOCATE or a flush abandons the transfer, with no resume after release. A pmem_resp arriving after release in IDLE is ignored.

Verification
REQ-041 Cold read at 0x1230, pmem returns line L after 5 cycles: one pmem_read at 0x1230, then mem_resp with mem_rdata=L. A repeat read gives mem_resp 2 cycles after request with no pmem activity.
REQ-042 Fill all 4 ways of set 3 (defaults), read ways 0, 1, 2, then miss on a new tag: way 3 is replaced.
REQ-043 Write line W to 0x0040 (miss, no fill), then five conflicting reads in set 4 evict it: pmem_write at 0x0040 with pmem_wdata=W precedes the pmem_read.
REQ-044 Dirty lines in set 0 way 1 and set 7 way 2, then flush_req=1: exactly two pmem_writes in (set, way) order, then a single flush_done; a later read of either line hits.
REQ-045 rst_n dropped mid-ALLOCATE: pmem_read goes to 0 asynchronously; after release, the prior address misses.
REQ-046 mem_read and flush_req rise together: the read completes first, then the flush runs.
